// File: rtl/msg_receive_parser.sv
// msg_receive_parser: SRIO downstream command receiver (frame hunt, checksum verify, command apply)
// Ports:
//   sys_clk_100m, sw_srst_n (async active-low)   clock / reset
//   ds_empty_i, ds_rd_en_o, ds_din_i              standard-mode downstream FIFO read side
//   msg_id_o, sim_data_en_o                       persistent command results
//   start_trigger_pluse_o, soft_rst_req_pluse_o   one-cycle command pulses
//   frame_ok_pluse_o, frame_err_pluse_o, err_cnt_o frame status and saturating error count
module msg_receive_parser #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int MAX_LEN        = 15
) (
    input  logic        sys_clk_100m,
    input  logic        sw_srst_n,
    input  logic        ds_empty_i,
    output logic        ds_rd_en_o,
    input  logic [31:0] ds_din_i,
    output logic [15:0] msg_id_o,
    output logic        sim_data_en_o,
    output logic        start_trigger_pluse_o,
    output logic        soft_rst_req_pluse_o,
    output logic        frame_ok_pluse_o,
    output logic        frame_err_pluse_o,
    output logic [15:0] err_cnt_o
);
    typedef enum logic [1:0] {HUNT, BODY, APPLY} state_t;
    localparam logic [7:0]  MAX_L = 8'(MAX_LEN);
    localparam logic [31:0] TMO_L = 32'(TIMEOUT_CYCLES - 1);
    state_t      state_q, state_d;
    logic        rd_q, rd_en;
    logic [7:0]  type_q, type_d, len_q, len_d, issued_q, issued_d, idx_q, idx_d;
    logic [31:0] sum_q, sum_d, p0_q, p0_d, chk_q, chk_d, timer_q, timer_d;
    logic [15:0] msg_id_q, msg_id_d, err_cnt_q, err_cnt_d;
    logic        sim_q, sim_d, start_q, start_d, srst_q, srst_d, ok_q, ok_d, err_q, err_d;
    logic        hdr, len_ok, tmo, good;
    logic [15:0] err_inc;
    // rd_q marks that ds_din_i holds a freshly read word this cycle
    assign hdr     = ds_din_i[31:16] == 16'hEB90;
    assign len_ok  = ds_din_i[7:0] <= MAX_L;
    assign tmo     = !rd_q && timer_q == TMO_L;
    assign err_inc = err_cnt_q == 16'hFFFF ? err_cnt_q : err_cnt_q + 16'd1;
    assign good    = chk_q == sum_q &&
                     ((type_q == 8'h01 && len_q == 8'd1) || (type_q == 8'h02 && len_q == 8'd0) ||
                      (type_q == 8'h03 && len_q == 8'd1) || (type_q == 8'h04 && len_q == 8'd0));
    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        len_d     = len_q;
        issued_d  = issued_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        p0_d      = p0_q;
        chk_d     = chk_q;
        timer_d   = timer_q;
        msg_id_d  = msg_id_q;
        err_cnt_d = err_cnt_q;
        sim_d     = sim_q;
        start_d   = 1'b0;
        srst_d    = 1'b0;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            HUNT: begin
                // one word at a time: never read while a word awaits decode
                rd_en = !ds_empty_i && !rd_q;
                if (rd_q && hdr && len_ok) begin
                    state_d  = BODY;
                    type_d   = ds_din_i[15:8];
                    len_d    = ds_din_i[7:0];
                    sum_d    = ds_din_i;
                    issued_d = 8'd0;
                    idx_d    = 8'd0;
                    timer_d  = 32'd0;
                end else if (rd_q && hdr) begin
                    err_d     = 1'b1;
                    err_cnt_d = err_inc;
                end
            end
            BODY: begin
                // len payload words plus the checksum: issued <= len means fewer than len+1 reads
                rd_en    = !ds_empty_i && issued_q <= len_q && !tmo;
                issued_d = issued_q + {7'd0, rd_en};
                timer_d  = rd_q ? 32'd0 : timer_q + 32'd1;
                if (rd_q && idx_q == len_q) begin
                    chk_d   = ds_din_i;
                    state_d = APPLY;
                end else if (rd_q) begin
                    sum_d = sum_q + ds_din_i;
                    p0_d  = idx_q == 8'd0 ? ds_din_i : p0_q;
                    idx_d = idx_q + 8'd1;
                end else if (tmo) begin
                    err_d     = 1'b1;
                    err_cnt_d = err_inc;
                    state_d   = HUNT;
                end
            end
            default: begin
                state_d   = HUNT;
                ok_d      = good;
                err_d     = !good;
                err_cnt_d = good ? err_cnt_q : err_inc;
                msg_id_d  = good && type_q == 8'h01 ? p0_q[15:0] : msg_id_q;
                sim_d     = good && type_q == 8'h03 ? p0_q[0] : sim_q;
                start_d   = good && type_q == 8'h02;
                srst_d    = good && type_q == 8'h04;
            end
        endcase
    end
    always_ff @(posedge sys_clk_100m or negedge sw_srst_n) begin
        if (!sw_srst_n) begin
            state_q   <= HUNT;
            rd_q      <= 1'b0;
            type_q    <= 8'd0;
            len_q     <= 8'd0;
            issued_q  <= 8'd0;
            idx_q     <= 8'd0;
            sum_q     <= 32'd0;
            p0_q      <= 32'd0;
            chk_q     <= 32'd0;
            timer_q   <= 32'd0;
            msg_id_q  <= 16'd0;
            err_cnt_q <= 16'd0;
            sim_q     <= 1'b0;
            start_q   <= 1'b0;
            srst_q    <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_en;
            type_q    <= type_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            p0_q      <= p0_d;
            chk_q     <= chk_d;
            timer_q   <= timer_d;
            msg_id_q  <= msg_id_d;
            err_cnt_q <= err_cnt_d;
            sim_q     <= sim_d;
            start_q   <= start_d;
            srst_q    <= srst_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
        end
    end
    assign ds_rd_en_o            = rd_en && sw_srst_n;
    assign msg_id_o              = msg_id_q;
    assign sim_data_en_o         = sim_q;
    assign start_trigger_pluse_o = start_q;
    assign soft_rst_req_pluse_o  = srst_q;
    assign frame_ok_pluse_o      = ok_q;
    assign frame_err_pluse_o     = err_q;
    assign err_cnt_o             = err_cnt_q;
endmodule
